gemm_vector_sequencer: RTL and testbench

Control-side partner of the GEMM dot-product datapath. It walks an output matrix C = A·B in row-major order. For each element it reads K vector chunks of one A row and one B column from two word-wide operand memories and drives them into the N-lane MAC/adder-tree unit. It sign-extends and accumulates the MAC results across chunks, then presents each finished C element on a valid/ready output port, so it both feeds the dot-product unit and collects its results.

---
 rtl/gemm_vector_sequencer_pkg.sv | 21 ++
 rtl/gemm_vector_sequencer_if.sv | 56 +++++
 rtl/gemm_vector_sequencer_index_counter.sv | 86 ++++++++
 rtl/gemm_vector_sequencer.sv | 159 +++++++++++++++
 tb/tb_gemm_vector_sequencer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gemm_vector_sequencer_pkg.sv
// Shared types for the GEMM vector sequencer: FSM states, operand vector shape
// and the accumulator width legality check.
package gemm_pkg;

   localparam int GEMM_N     = 8;
   localparam int GEMM_WIDTH = 16;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DRAIN,
      OUT
   } state_t;

   typedef logic signed [GEMM_N-1:0][GEMM_WIDTH-1:0] vec_t;

   function automatic bit acc_w_legal(input int acc_w, input int width);
      return acc_w >= 2 * width;
   endfunction

endpackage

// File: rtl/gemm_vector_sequencer_if.sv
// Bus bundle between the GEMM vector sequencer and its environment: job control,
// operand memory reads, MAC unit hookup and the result handshake.
interface gemm_vector_sequencer_if #(
   parameter int N     = 8,
   parameter int WIDTH = 16,
   parameter int DIM_W = 8,
   parameter int ACC_W = 40
);

   logic                            start;
   logic [DIM_W-1:0]                cfg_m;
   logic [DIM_W-1:0]                cfg_n;
   logic [DIM_W-1:0]                cfg_k;
   logic                            busy;
   logic                            done;

   logic                            a_rd_en;
   logic                            b_rd_en;
   logic [2*DIM_W-1:0]              a_rd_addr;
   logic [2*DIM_W-1:0]              b_rd_addr;
   logic signed [N-1:0][WIDTH-1:0]  a_rd_data;
   logic signed [N-1:0][WIDTH-1:0]  b_rd_data;

   logic signed [N-1:0][WIDTH-1:0]  mac_vec_a;
   logic signed [N-1:0][WIDTH-1:0]  mac_vec_b;
   logic signed [2*WIDTH-1:0]       mac_result;

   logic                            out_valid;
   logic                            out_ready;
   logic signed [ACC_W-1:0]         out_data;
   logic [DIM_W-1:0]                out_row;
   logic [DIM_W-1:0]                out_col;

   modport master (
      input  start, cfg_m, cfg_n, cfg_k,
      output busy, done,
      output a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
      input  a_rd_data, b_rd_data,
      output mac_vec_a, mac_vec_b,
      input  mac_result,
      output out_valid, out_data, out_row, out_col,
      input  out_ready
   );

   modport slave (
      output start, cfg_m, cfg_n, cfg_k,
      input  busy, done,
      input  a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
      output a_rd_data, b_rd_data,
      input  mac_vec_a, mac_vec_b,
      output mac_result,
      input  out_valid, out_data, out_row, out_col,
      output out_ready
   );

endinterface

// File: rtl/gemm_vector_sequencer_index_counter.sv
// Nested i/j/k walk over the output matrix with running row/column base
// addresses, so word addresses need no multiplier.
module gemm_index_counter #(
   parameter int DIM_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [DIM_W-1:0]   cfg_m,
   input  logic [DIM_W-1:0]   cfg_n,
   input  logic [DIM_W-1:0]   cfg_k,
   input  logic               k_step,
   input  logic               elem_step,
   output logic [DIM_W-1:0]   i_idx,
   output logic [DIM_W-1:0]   j_idx,
   output logic [DIM_W-1:0]   k_idx,
   output logic               k_last,
   output logic               elem_last,
   output logic [2*DIM_W-1:0] a_addr,
   output logic [2*DIM_W-1:0] b_addr
);

   localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

   logic [DIM_W-1:0]   m_cfg;
   logic [DIM_W-1:0]   n_cfg;
   logic [DIM_W-1:0]   k_cfg;
   logic [2*DIM_W-1:0] a_base;
   logic [2*DIM_W-1:0] b_base;
   logic [2*DIM_W-1:0] k_ext;
   logic               i_last;
   logic               j_last;

   assign k_last    = (k_idx == k_cfg - ONE);
   assign j_last    = (j_idx == n_cfg - ONE);
   assign i_last    = (i_idx == m_cfg - ONE);
   assign elem_last = i_last && j_last;

   // a_base tracks i*cfg_k and b_base tracks j*cfg_k (B is column-major)
   assign k_ext  = {{DIM_W{1'b0}}, k_cfg};
   assign a_addr = a_base + {{DIM_W{1'b0}}, k_idx};
   assign b_addr = b_base + {{DIM_W{1'b0}}, k_idx};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cfg  <= '0;
         n_cfg  <= '0;
         k_cfg  <= '0;
         i_idx  <= '0;
         j_idx  <= '0;
         k_idx  <= '0;
         a_base <= '0;
         b_base <= '0;
      end else if (load) begin
         m_cfg  <= cfg_m;
         n_cfg  <= cfg_n;
         k_cfg  <= cfg_k;
         i_idx  <= '0;
         j_idx  <= '0;
         k_idx  <= '0;
         a_base <= '0;
         b_base <= '0;
      end else begin
         if (k_step) begin
            k_idx <= k_last ? '0 : k_idx + ONE;
         end
         if (elem_step) begin
            if (j_last) begin
               j_idx  <= '0;
               b_base <= '0;
               if (i_last) begin
                  i_idx  <= '0;
                  a_base <= '0;
               end else begin
                  i_idx  <= i_idx + ONE;
                  a_base <= a_base + k_ext;
               end
            end else begin
               j_idx  <= j_idx + ONE;
               b_base <= b_base + k_ext;
            end
         end
      end
   end

endmodule

// File: rtl/gemm_vector_sequencer.sv
// Walks C = A*B element by element, streams operand chunks into the external
// MAC unit and accumulates its results into one C element per handshake.
module gemm_vector_sequencer
   import gemm_pkg::*;
#(
   parameter int N       = GEMM_N,
   parameter int WIDTH   = GEMM_WIDTH,
   parameter int DIM_W   = 8,
   parameter int MAC_LAT = 1,
   parameter int ACC_W   = 40
) (
   input  logic              clk,
   input  logic              rst_n,
   gemm_vector_sequencer_if.master bus
);

   if (!acc_w_legal(ACC_W, WIDTH)) begin : g_acc_w_check
      $error("ACC_W must be at least 2*WIDTH");
   end
   if (MAC_LAT < 1 || N < 1) begin : g_shape_check
      $error("MAC_LAT and N must be at least 1");
   end

   state_t                  state;
   state_t                  state_nxt;
   logic                    load;
   logic                    k_step;
   logic                    elem_step;
   logic                    done_nxt;
   logic                    done_r;
   logic                    rd_en;
   logic                    cfg_zero;
   logic                    pending;
   logic [DIM_W-1:0]        i_idx;
   logic [DIM_W-1:0]        j_idx;
   logic [DIM_W-1:0]        k_idx;
   logic                    k_last;
   logic                    elem_last;
   logic [2*DIM_W-1:0]      a_addr;
   logic [2*DIM_W-1:0]      b_addr;
   logic [MAC_LAT:0]        vld_p;
   logic [MAC_LAT:0]        first_p;
   logic signed [ACC_W-1:0] acc;

   function automatic logic signed [ACC_W-1:0] sext(input logic signed [2*WIDTH-1:0] v);
      return ACC_W'(v);
   endfunction

   gemm_index_counter #(
      .DIM_W (DIM_W)
   ) u_index (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load),
      .cfg_m     (bus.cfg_m),
      .cfg_n     (bus.cfg_n),
      .cfg_k     (bus.cfg_k),
      .k_step    (k_step),
      .elem_step (elem_step),
      .i_idx     (i_idx),
      .j_idx     (j_idx),
      .k_idx     (k_idx),
      .k_last    (k_last),
      .elem_last (elem_last),
      .a_addr    (a_addr),
      .b_addr    (b_addr)
   );

   assign cfg_zero = (bus.cfg_m == '0) || (bus.cfg_n == '0) || (bus.cfg_k == '0);
   assign rd_en    = (state == ISSUE);
   // Only the oldest tag may still be live when leaving DRAIN; it lands in acc on that edge
   assign pending  = |vld_p[MAC_LAT-1:0];

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      k_step    = 1'b0;
      elem_step = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               if (cfg_zero) begin
                  done_nxt = 1'b1;
               end else begin
                  load      = 1'b1;
                  state_nxt = ISSUE;
               end
            end
         end
         ISSUE: begin
            k_step = 1'b1;
            if (k_last) begin
               state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            if (!pending) begin
               state_nxt = OUT;
            end
         end
         OUT: begin
            if (bus.out_ready) begin
               elem_step = 1'b1;
               if (elem_last) begin
                  done_nxt  = 1'b1;
                  state_nxt = IDLE;
               end else begin
                  state_nxt = ISSUE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         done_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_r <= done_nxt;
      end
   end

   // p0: read data returned; pMAC_LAT: mac_result for that chunk
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p   <= '0;
         first_p <= '0;
      end else begin
         vld_p   <= {vld_p[MAC_LAT-1:0], rd_en};
         first_p <= {first_p[MAC_LAT-1:0], rd_en && (k_idx == '0)};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
      end else if (vld_p[MAC_LAT]) begin
         acc <= first_p[MAC_LAT] ? sext(bus.mac_result) : acc + sext(bus.mac_result);
      end
   end

   assign bus.busy      = (state != IDLE);
   assign bus.done      = done_r;
   assign bus.a_rd_en   = rd_en;
   assign bus.b_rd_en   = rd_en;
   assign bus.a_rd_addr = a_addr;
   assign bus.b_rd_addr = b_addr;
   assign bus.mac_vec_a = vld_p[0] ? bus.a_rd_data : '0;
   assign bus.mac_vec_b = vld_p[0] ? bus.b_rd_data : '0;
   assign bus.out_valid = (state == OUT);
   assign bus.out_data  = acc;
   assign bus.out_row   = i_idx;
   assign bus.out_col   = j_idx;

endmodule

// File: tb/tb_gemm_vector_sequencer.sv
// Directed bench for gemm_vector_sequencer with a behavioural operand memory
// and a one-cycle MAC model.
module tb_gemm_vector_sequencer;
   import gemm_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   vec_t mem_a [32];
   vec_t mem_b [32];

   int                exp_row [4] = '{0, 0, 1, 1};
   int                exp_col [4] = '{0, 1, 0, 1};
   logic signed [39:0] exp_c  [4] = '{-40'sd56, 40'sd184, 40'sd312, -40'sd88};
   logic signed [39:0] big_c      = 40'sd8589934592;

   gemm_vector_sequencer_if #(.N(8), .WIDTH(16), .DIM_W(8), .ACC_W(40)) bus ();

   gemm_vector_sequencer #(
      .N(8), .WIDTH(16), .DIM_W(8), .MAC_LAT(1), .ACC_W(40)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   function automatic logic signed [31:0] dot(input vec_t a, input vec_t b);
      logic signed [31:0] s;
      s = '0;
      for (int l = 0; l < 8; l++) s = s + $signed(a[l]) * $signed(b[l]);
      return s;
   endfunction

   // Operand memories (1-cycle read latency) and a MAC with MAC_LAT = 1
   always @(posedge clk) begin
      if (bus.a_rd_en) bus.a_rd_data <= mem_a[bus.a_rd_addr[4:0]];
      if (bus.b_rd_en) bus.b_rd_data <= mem_b[bus.b_rd_addr[4:0]];
      bus.mac_result <= dot(bus.mac_vec_a, bus.mac_vec_b);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_job(input int m, input int n, input int k);
      bus.cfg_m = 8'(m);
      bus.cfg_n = 8'(n);
      bus.cfg_k = 8'(k);
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   task automatic wait_out(input int bound);
      int n;
      n = 0;
      while (!bus.out_valid && n < bound) begin
         tick();
         n++;
      end
      chk("wait_out_valid", bus.out_valid, 1);
   endtask

   task automatic clear_mem();
      for (int a = 0; a < 32; a++) begin
         mem_a[a] = '0;
         mem_b[a] = '0;
      end
   endtask

   task automatic set_all(input int addr, input int av, input int bv);
      for (int l = 0; l < 8; l++) begin
         mem_a[addr][l] = 16'(av);
         mem_b[addr][l] = 16'(bv);
      end
   endtask

   // A chunk all ones, B chunk 1..8: dot product 36
   task automatic load_basic();
      clear_mem();
      for (int l = 0; l < 8; l++) begin
         mem_a[0][l] = 16'd1;
         mem_b[0][l] = 16'(l + 1);
      end
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_valid"}, bus.out_valid, 0);
      chk({tag, "_busy"},  bus.busy, 0);
      chk({tag, "_done"},  bus.done, 0);
      chk({tag, "_rd_en"}, {bus.a_rd_en, bus.b_rd_en}, 0);
      chk({tag, "_addr"},  {bus.a_rd_addr, bus.b_rd_addr}, 0);
      chk({tag, "_data"},  bus.out_data, 0);
      chk({tag, "_rowcol"}, {bus.out_row, bus.out_col}, 0);
      chk({tag, "_vec"},   {bus.mac_vec_a, bus.mac_vec_b}, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.start     = 1'b0;
      bus.cfg_m     = '0;
      bus.cfg_n     = '0;
      bus.cfg_k     = '0;
      bus.out_ready = 1'b1;
      clear_mem();

      repeat (3) @(posedge clk);
      #1;
      check_idle_zero("reset");
      rst_n = 1'b1;
      tick();

      // Single element, single chunk
      load_basic();
      start_job(1, 1, 1);
      chk("t1_rd_en_c1", {bus.a_rd_en, bus.b_rd_en}, 2'b11);
      chk("t1_addr_c1", {bus.a_rd_addr, bus.b_rd_addr}, 0);
      chk("t1_busy_c1", bus.busy, 1);
      tick();
      chk("t1_vec_a_c2", bus.mac_vec_a, mem_a[0]);
      chk("t1_vec_b_c2", bus.mac_vec_b, mem_b[0]);
      chk("t1_rd_en_c2", bus.a_rd_en, 0);
      tick();
      chk("t1_valid_c3", bus.out_valid, 0);
      tick();
      chk("t1_valid_c4", bus.out_valid, 1);
      chk("t1_data", bus.out_data, 36);
      chk("t1_rowcol", {bus.out_row, bus.out_col}, 0);
      chk("t1_done_c4", bus.done, 0);
      tick();
      chk("t1_done_c5", bus.done, 1);
      chk("t1_busy_c5", bus.busy, 0);
      chk("t1_valid_c5", bus.out_valid, 0);
      tick();
      chk("t1_done_c6", bus.done, 0);
      repeat (2) tick();

      // Three chunks: 3 * 8 * (2*3) = 144
      clear_mem();
      for (int a = 0; a < 3; a++) set_all(a, 2, 3);
      start_job(1, 1, 3);
      for (int c = 0; c < 3; c++) begin
         chk("t2_rd_en", bus.a_rd_en, 1);
         chk("t2_a_addr", bus.a_rd_addr, c);
         chk("t2_b_addr", bus.b_rd_addr, c);
         tick();
      end
      chk("t2_rd_en_c4", bus.a_rd_en, 0);
      tick();
      chk("t2_valid_c5", bus.out_valid, 0);
      tick();
      chk("t2_valid_c6", bus.out_valid, 1);
      chk("t2_data", bus.out_data, 144);
      tick();
      chk("t2_done", bus.done, 1);
      repeat (2) tick();

      // Eight chunks of one lane at -32768 * -32768 = 2^30 each: 2^33 without wrap
      clear_mem();
      for (int a = 0; a < 8; a++) begin
         mem_a[a][0] = 16'h8000;
         mem_b[a][0] = 16'h8000;
      end
      start_job(1, 1, 8);
      wait_out(20);
      chk("t3_data", bus.out_data, big_c);
      tick();
      chk("t3_done", bus.done, 1);
      repeat (2) tick();

      // 2x2x2 with a 5-cycle stall on the first result
      clear_mem();
      set_all(0, 1, 5);
      set_all(1, 2, -6);
      set_all(2, 3, 7);
      set_all(3, -4, 8);
      bus.out_ready = 1'b0;
      start_job(2, 2, 2);
      wait_out(20);
      for (int s = 0; s < 5; s++) begin
         chk("t4_stall_valid", bus.out_valid, 1);
         chk("t4_stall_data", bus.out_data, exp_c[0]);
         chk("t4_stall_rowcol", {bus.out_row, bus.out_col}, 0);
         chk("t4_stall_rd_en", {bus.a_rd_en, bus.b_rd_en}, 0);
         tick();
      end
      bus.out_ready = 1'b1;
      for (int e = 0; e < 4; e++) begin
         wait_out(20);
         chk("t4_row", bus.out_row, exp_row[e]);
         chk("t4_col", bus.out_col, exp_col[e]);
         chk("t4_data", bus.out_data, exp_c[e]);
         tick();
         if (e == 0) begin
            chk("t4_j1_rd_en", bus.b_rd_en, 1);
            chk("t4_j1_b_addr0", bus.b_rd_addr, 2);
            chk("t4_j1_a_addr0", bus.a_rd_addr, 0);
            tick();
            chk("t4_j1_b_addr1", bus.b_rd_addr, 3);
            chk("t4_j1_a_addr1", bus.a_rd_addr, 1);
         end
      end
      chk("t4_done", bus.done, 1);
      chk("t4_busy", bus.busy, 0);
      repeat (2) tick();

      // Zero dimension: immediate done, nothing issued
      start_job(1, 1, 0);
      chk("t5_done_c1", bus.done, 1);
      chk("t5_busy_c1", bus.busy, 0);
      chk("t5_rd_en_c1", bus.a_rd_en, 0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk("t5_idle_busy", bus.busy, 0);
         chk("t5_idle_rd_en", bus.a_rd_en, 0);
         chk("t5_idle_done", bus.done, 0);
      end

      // start while busy is ignored
      load_basic();
      start_job(1, 1, 1);
      bus.cfg_m = 8'd2;
      bus.cfg_n = 8'd2;
      bus.cfg_k = 8'd2;
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
      tick();
      tick();
      chk("t5b_valid_c4", bus.out_valid, 1);
      chk("t5b_data", bus.out_data, 36);
      tick();
      chk("t5b_done", bus.done, 1);
      chk("t5b_busy", bus.busy, 0);
      repeat (2) tick();

      // Asynchronous reset in the middle of ISSUE
      clear_mem();
      for (int a = 0; a < 4; a++) set_all(a, 3, 4);
      start_job(1, 1, 4);
      tick();
      chk("t6_pre_a_addr", bus.a_rd_addr, 1);
      rst_n = 1'b0;
      #1;
      check_idle_zero("t6_rst");
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_post_valid", bus.out_valid, 0);
      load_basic();
      start_job(1, 1, 1);
      tick();
      tick();
      tick();
      chk("t6_valid_c4", bus.out_valid, 1);
      chk("t6_data", bus.out_data, 36);
      tick();
      chk("t6_done", bus.done, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
